// File: rtl/bram_tdp_pipe.sv
// bram_tdp_pipe: true dual-port byte-writable RAM with per-lane collision merge,
// a 1- or 2-cycle read pipeline and a saturating collision counter.
module bram_tdp_pipe #(
  parameter int    DATA_W       = 64,
  parameter int    ADDR_W       = 15,
  parameter int    READ_LATENCY = 1,
  parameter string WRITE_MODE   = "READ_FIRST",
  parameter bit    PRIO_A       = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                portA_EN,
  input  logic [DATA_W/8-1:0] portA_WE,
  input  logic [ADDR_W-1:0]   portA_ADDR,
  input  logic [DATA_W-1:0]   portA_DI,
  output logic [DATA_W-1:0]   portA_DO,
  output logic                portA_VALID,
  input  logic                portB_EN,
  input  logic [DATA_W/8-1:0] portB_WE,
  input  logic [ADDR_W-1:0]   portB_ADDR,
  input  logic [DATA_W-1:0]   portB_DI,
  output logic [DATA_W-1:0]   portB_DO,
  output logic                portB_VALID,
  output logic                collision,
  output logic [15:0]         collision_cnt
);
  localparam int NB = DATA_W / 8;
  localparam bit WF = (WRITE_MODE == "WRITE_FIRST");
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic acc_a, acc_b, same, hit;
  logic [NB-1:0] wm_a, wm_b;
  logic [DATA_W-1:0] old_a, old_b, rv_a, rv_b, da1, db1, da2, db2;
  logic va1, vb1, va2, vb2;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, ds, dx,
                                               input logic [NB-1:0] ms, mx);
    logic [DATA_W-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++)
      r[i*8+:8] = ms[i] ? ds[i*8+:8] : mx[i] ? dx[i*8+:8] : o[i*8+:8];
    return r;
  endfunction
  // Lanes both ports write at the same address are masked off the losing port,
  // so the two write masks never overlap and write order does not matter.
  always_comb begin
    acc_a = portA_EN & ~reset;
    acc_b = portB_EN & ~reset;
    same  = acc_a & acc_b & (portA_ADDR == portB_ADDR);
    hit   = same & (|{portA_WE, portB_WE});
    wm_a  = acc_a ? portA_WE & ~((same & ~PRIO_A) ? portB_WE : '0) : '0;
    wm_b  = acc_b ? portB_WE & ~((same & PRIO_A) ? portA_WE : '0) : '0;
    old_a = mem[portA_ADDR];
    old_b = mem[portB_ADDR];
    rv_a  = (WF && |portA_WE) ? merge(old_a, portA_DI, portB_DI, wm_a, same ? wm_b : '0) : old_a;
    rv_b  = (WF && |portB_WE) ? merge(old_b, portB_DI, portA_DI, wm_b, same ? wm_a : '0) : old_b;
  end
  always_ff @(posedge clock)
    for (int i = 0; i < NB; i++) begin
      if (wm_a[i]) mem[portA_ADDR][i*8+:8] <= portA_DI[i*8+:8];
      if (wm_b[i]) mem[portB_ADDR][i*8+:8] <= portB_DI[i*8+:8];
    end
  always_ff @(posedge clock) begin
    if (reset) begin
      {va1, vb1, va2, vb2, collision} <= '0;
      {da1, db1, da2, db2} <= '0;
      collision_cnt <= '0;
    end else begin
      va1 <= acc_a;
      vb1 <= acc_b;
      va2 <= va1;
      vb2 <= vb1;
      if (acc_a) da1 <= rv_a;
      if (acc_b) db1 <= rv_b;
      if (va1) da2 <= da1;
      if (vb1) db2 <= db1;
      collision <= hit;
      if (hit && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
    end
  end
  assign portA_DO    = (READ_LATENCY == 2) ? da2 : da1;
  assign portB_DO    = (READ_LATENCY == 2) ? db2 : db1;
  assign portA_VALID = (READ_LATENCY == 2) ? va2 : va1;
  assign portB_VALID = (READ_LATENCY == 2) ? vb2 : vb1;
endmodule
